// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a byte stream (valid/ready) framed as a 2-byte big-endian word count
// followed by that many big-endian 32-bit words, and writes the words to the
// instruction memory from word address 0 upward. The datapath is held in stall
// while a load is in progress or after a rejected header.
module imem_loader #(
  parameter int ADDR_W = 8  // word-address width; header count is 16 bits, so keep ADDR_W <= 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int MAX_WORDS = 1 << ADDR_W;
  // Header count compared one bit wider so MAX_WORDS itself is representable.
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [7:0]          cnt_hi_reg;
  logic [31:0]         word_reg;
  logic [1:0]          byte_cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W:0]     words_left_reg;
  logic [ADDR_W:0]     words_loaded_reg;

  logic                accept;
  logic [15:0]         hdr_count;
  logic                hdr_too_big;

  assign accept      = in_valid && in_ready;
  assign hdr_count   = {cnt_hi_reg, in_data};
  assign hdr_too_big = {1'b0, hdr_count} > MAX_N;

  // Write port and progress counter come straight from registers so they are
  // stable for the whole WRITE cycle and zero out of reset.
  assign mem_addr     = addr_reg;
  assign mem_wdata    = word_reg;
  assign words_loaded = words_loaded_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    cpu_hold   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) state_next = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) begin
          if (hdr_count == 16'd0)  state_next = S_DONE;
          else if (hdr_too_big)    state_next = S_ERR;
          else                     state_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid && byte_cnt_reg == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        if (words_left_reg == (ADDR_W+1)'(1)) state_next = S_DONE;
        else                                  state_next = S_DATA;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) state_next = S_HDR_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: header capture, word assembly and write-address bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_hi_reg       <= 8'd0;
      word_reg         <= 32'd0;
      byte_cnt_reg     <= 2'd0;
      addr_reg         <= '0;
      words_left_reg   <= '0;
      words_loaded_reg <= '0;
    end else begin
      case (state_reg)
        S_HDR_HI: begin
          if (accept) cnt_hi_reg <= in_data;
        end
        S_HDR_LO: begin
          if (accept) begin
            // Cleared for every header so an empty or rejected load reports zero.
            words_loaded_reg <= '0;
            words_left_reg   <= hdr_count[ADDR_W:0];
            addr_reg         <= '0;
            byte_cnt_reg     <= 2'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
            word_reg     <= {word_reg[23:0], in_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
          end
        end
        S_WRITE: begin
          // Address wraps only after the final word of a full-size load.
          addr_reg         <= addr_reg + ADDR_W'(1);
          words_loaded_reg <= words_loaded_reg + (ADDR_W+1)'(1);
          words_left_reg   <= words_left_reg - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames, a byte-stream model that predicts
// every output cycle by cycle, and literal checks on the resulting memory image.
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory image built from observed writes, plus event counters.
  logic [31:0] mem_img [0:MAX_WORDS-1];
  int we_count   = 0;
  int done_count = 0;

  // Model: tracks the frame by accepted-byte index and predicts the outputs.
  logic        m_loading = 0, m_we = 0, m_done = 0, m_err = 0, m_ready = 0;
  logic [31:0] m_word = 0, m_data = 0;
  int          m_k = 0, m_n = 0, m_widx = 0, m_wl = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs",
            {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded}, 64'd0);
        m_loading = 0; m_we = 0; m_done = 0; m_err = 0; m_ready = 0;
        m_k = 0; m_n = 0; m_widx = 0; m_wl = 0; m_word = 0;
      end else begin
        logic n_loading, n_we, n_done, n_err, n_ready;
        int   n_wl;
        chk("in_ready", in_ready, m_ready);
        chk("mem_we", mem_we, m_we);
        if (m_we) begin
          chk("mem_addr", mem_addr, m_widx % MAX_WORDS);
          chk("mem_wdata", mem_wdata, m_data);
        end
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("cpu_hold", cpu_hold, m_loading || m_err);
        chk("words_loaded", words_loaded, m_wl);
        if (mem_we) begin
          mem_img[mem_addr] = mem_wdata;
          we_count++;
        end
        if (done) done_count++;

        n_loading = m_loading; n_we = 0; n_done = 0; n_err = m_err;
        n_ready = m_ready; n_wl = m_wl;
        if (m_we) begin
          n_wl = m_wl + 1;
          if (m_widx + 1 == m_n) begin
            n_done = 1; n_loading = 0; n_ready = 0;
          end else begin
            n_ready = 1;
          end
        end
        if (!m_loading && !m_done && start) begin
          n_loading = 1; n_ready = 1; n_err = 0; m_k = 0;
        end
        if (in_valid && m_ready) begin
          if (m_k == 0) begin
            m_n = int'(in_data) * 256;
          end else if (m_k == 1) begin
            m_n = m_n + int'(in_data);
            n_wl = 0;
            if (m_n == 0) begin
              n_done = 1; n_loading = 0; n_ready = 0;
            end else if (m_n > MAX_WORDS) begin
              n_err = 1; n_loading = 0; n_ready = 0;
            end
          end else begin
            m_word = {m_word[23:0], in_data};
            if ((m_k - 2) % 4 == 3) begin
              n_we = 1; n_ready = 0; m_widx = (m_k - 2) / 4; m_data = m_word;
            end
          end
          m_k++;
        end
        m_loading = n_loading; m_we = n_we; m_done = n_done; m_err = n_err;
        m_ready = n_ready; m_wl = n_wl;
      end
    end
  end

  logic [7:0] frame_q[$];

  // Present one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int t;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        chk("byte_accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    foreach (frame_q[i]) send_byte(frame_q[i], gap_max);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    for (int t = 0; t < budget && done_count == d0; t++) @(negedge clk);
    chk(name, done_count - d0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_cpu_hold", cpu_hold, 0);
    @(posedge clk); #1;

    // Two words, continuous valid.
    w0 = we_count; d0 = done_count;
    pulse_start();
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(0);
    wait_done("t2_done", d0, 50);
    chk("t2_word0", mem_img[0], 32'h12345678);
    chk("t2_word1", mem_img[1], 32'hDEADBEEF);
    chk("t2_writes", we_count - w0, 2);
    chk("t2_words_loaded", words_loaded, 2);

    // Same frame with random valid gaps.
    mem_img[0] = 0; mem_img[1] = 0;
    w0 = we_count; d0 = done_count;
    pulse_start();
    send_frame(3);
    wait_done("t3_done", d0, 100);
    chk("t3_word0", mem_img[0], 32'h12345678);
    chk("t3_word1", mem_img[1], 32'hDEADBEEF);
    chk("t3_writes", we_count - w0, 2);

    // Empty frame.
    w0 = we_count; d0 = done_count;
    pulse_start();
    frame_q = '{8'h00, 8'h00};
    send_frame(0);
    wait_done("t4_done", d0, 20);
    chk("t4_writes", we_count - w0, 0);
    chk("t4_words_loaded", words_loaded, 0);
    chk("t4_error", error, 0);

    // Oversize header, then recovery from the error state.
    w0 = we_count;
    pulse_start();
    frame_q = '{8'h01, 8'h01};
    send_frame(0);
    repeat (3) @(negedge clk);
    chk("t5_error", error, 1);
    chk("t5_cpu_hold", cpu_hold, 1);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_no_writes", we_count - w0, 0);
    @(posedge clk); #1;
    d0 = done_count;
    pulse_start();
    frame_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_frame(0);
    wait_done("t5_done", d0, 30);
    chk("t5_word0", mem_img[0], 32'hCAFEBABE);
    chk("t5_error_cleared", error, 0);

    // Reset in the middle of a word.
    w0 = we_count;
    pulse_start();
    frame_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_frame(0);
    rst_n = 1'b0;
    #1;
    chk("t6_async_in_ready", in_ready, 0);
    chk("t6_async_cpu_hold", cpu_hold, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t6_no_writes", we_count - w0, 0);
    d0 = done_count;
    pulse_start();
    frame_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(0);
    wait_done("t6_done", d0, 30);
    chk("t6_word0", mem_img[0], 32'h11223344);

    // Full-size load of MAX_WORDS words.
    w0 = we_count; d0 = done_count;
    frame_q = '{8'h01, 8'h00};
    for (int i = 0; i < MAX_WORDS; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      frame_q.push_back(iv);
      frame_q.push_back(8'hA5);
      frame_q.push_back(~iv);
      frame_q.push_back(8'h3C);
    end
    pulse_start();
    send_frame(0);
    wait_done("t7_done", d0, 100);
    chk("t7_word0", mem_img[0], 32'h00A5FF3C);
    chk("t7_word255", mem_img[255], 32'hFFA5003C);
    chk("t7_writes", we_count - w0, MAX_WORDS);
    chk("t7_words_loaded", words_loaded, MAX_WORDS);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
